// File: rtl/round_key_fetch.sv
// round_key_fetch: stores expanded key words and sequences 128-bit round keys.
// Optional macro PREFETCH_EN adds a one-key prefetch buffer.
module round_key_fetch #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [DW-1:0]   wr_data_i,
  input  logic            key_ready_i,
  input  logic [1:0]      key_mode_i,
  input  logic            start_i,
  input  logic            ende_i,
  input  logic            key_next_i,
  output logic            rk_valid_o,
  output logic [2*DW-1:0] rk_data_o,
  output logic [3:0]      rk_round_o,
  output logic            rk_last_o,
  output logic            busy_o,
  output logic            err_o
);

  typedef enum logic [1:0] {IDLE, RD_HI, RD_LO, HOLD} state_t;

  state_t state_q, state_d;

  logic [DW-1:0] mem_q [2**AW];

  logic [3:0]    idx_q, nr_q, nr_sel, fin_idx, round_q;
  logic          dec_q, valid_q, last_q, err_q;
  logic [DW-1:0] hi_q, lo_q, rd_hi, rd_lo;
  logic [AW-1:0] addr_hi, addr_lo;
  logic          go, abort, fill, consume, fin;

`ifdef PREFETCH_EN
  logic [DW-1:0] bhi_q, blo_q;
  logic [3:0]    bround_q;
  logic          blast_q, bfull_q, done_q;
`endif

  assign nr_sel  = (key_mode_i == 2'd0) ? 4'd10 :
                   (key_mode_i == 2'd1) ? 4'd12 : 4'd14;
  assign fin_idx = dec_q ? 4'd0 : nr_q;
  assign fin     = (idx_q == fin_idx);
  assign go      = (state_q == IDLE) && start_i && key_ready_i;
  assign abort   = (state_q != IDLE) && !key_ready_i;
  assign fill    = (state_q == RD_LO) && !abort;
  assign consume = valid_q && key_next_i && !abort;
  assign addr_hi = AW'({idx_q, 1'b0});
  assign addr_lo = AW'({idx_q, 1'b1});
  assign rd_hi   = mem_q[addr_hi];
  assign rd_lo   = mem_q[addr_lo];

  // Key-word array: written any time, never reset.
  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: fetch hi, fetch lo, then wait for the core.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (go) state_d = RD_HI;
        RD_HI: state_d = RD_LO;
`ifdef PREFETCH_EN
        RD_LO: state_d = (!fin && (consume || !valid_q)) ? RD_HI : HOLD;
        HOLD: begin
          if (consume && last_q)
            state_d = IDLE;
          else if (!done_q && (!bfull_q || consume))
            state_d = RD_HI;
        end
`else
        RD_LO: state_d = HOLD;
        HOLD:  if (key_next_i) state_d = last_q ? IDLE : RD_HI;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Index, latched mode and round-key output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q    <= '0;
      nr_q     <= '0;
      dec_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      round_q  <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PREFETCH_EN
      bhi_q    <= '0;
      blo_q    <= '0;
      bround_q <= '0;
      blast_q  <= 1'b0;
      bfull_q  <= 1'b0;
      done_q   <= 1'b0;
`endif
    end else begin
      err_q <= (state_q == IDLE) && start_i && !key_ready_i;
      if (go) begin
        idx_q <= ende_i ? nr_sel : 4'd0;
        nr_q  <= nr_sel;
        dec_q <= ende_i;
      end
      if (fill && !fin) idx_q <= dec_q ? idx_q - 4'd1 : idx_q + 4'd1;
`ifdef PREFETCH_EN
      if (go) done_q <= 1'b0;
      if (fill) done_q <= fin;
      if (state_q == RD_HI && !abort) bhi_q <= rd_hi;
      if (consume && bfull_q) begin
        hi_q    <= bhi_q;
        lo_q    <= blo_q;
        round_q <= bround_q;
        last_q  <= blast_q;
        bfull_q <= 1'b0;
      end else if (fill && (consume || !valid_q)) begin
        hi_q    <= bhi_q;
        lo_q    <= rd_lo;
        round_q <= idx_q;
        last_q  <= fin;
        valid_q <= 1'b1;
      end else if (fill) begin
        blo_q    <= rd_lo;
        bround_q <= idx_q;
        blast_q  <= fin;
        bfull_q  <= 1'b1;
      end else if (consume) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
      if (abort) bfull_q <= 1'b0;
`else
      if (state_q == RD_HI && !abort) hi_q <= rd_hi;
      if (fill) begin
        lo_q    <= rd_lo;
        round_q <= idx_q;
        last_q  <= fin;
        valid_q <= 1'b1;
      end
      if (consume) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
`endif
      if (abort) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign rk_valid_o = valid_q;
  assign rk_data_o  = {hi_q, lo_q};
  assign rk_round_o = round_q;
  assign rk_last_o  = last_q;
  assign busy_o     = (state_q != IDLE);
  assign err_o      = err_q;

endmodule
